// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: packs valid-qualified pixel beats into words, buffers them in a FIFO, streams out with tlast.
// PIXEL_PACKER_PARTIAL_WORD_EN: emit a zero-padded final word when a frame does not fill whole words.
module pixel_stream_packer #(
    parameter int PIXEL_DATA_WIDTH = 8,
    parameter int PPC              = 1,
    parameter int OUT_DATA_WIDTH   = 32,
`ifdef PIXEL_PACKER_PARTIAL_WORD_EN
    parameter int FRAME_PIXELS     = 9,
`else
    parameter int FRAME_PIXELS     = 8,
`endif
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PPC*PIXEL_DATA_WIDTH-1:0]   in_pixel_data,
    input  logic                              in_pixel_data_valid,
    output logic [OUT_DATA_WIDTH-1:0]         out_tdata,
    output logic                              out_tvalid,
    input  logic                              out_tready,
    output logic                              out_tlast,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);
    localparam int PPW = OUT_DATA_WIDTH / PIXEL_DATA_WIDTH;
    localparam int SW  = PPW > 1 ? $clog2(PPW) : 1;
    localparam int CW  = FRAME_PIXELS > 1 ? $clog2(FRAME_PIXELS) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = OUT_DATA_WIDTH + 1;

    if (PPC != 1 && PPC != 2) begin : g_bad_ppc
        $error("PPC must be 1 or 2");
    end
    if (OUT_DATA_WIDTH % (PPC * PIXEL_DATA_WIDTH) != 0) begin : g_bad_width
        $error("OUT_DATA_WIDTH must be a multiple of PPC*PIXEL_DATA_WIDTH");
    end
    if (FRAME_PIXELS % PPC != 0) begin : g_bad_frame
        $error("FRAME_PIXELS must be a multiple of PPC");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 4");
    end
`ifndef PIXEL_PACKER_PARTIAL_WORD_EN
    if (FRAME_PIXELS % PPW != 0) begin : g_bad_partial
        $error("FRAME_PIXELS must be a multiple of pixels per word without PIXEL_PACKER_PARTIAL_WORD_EN");
    end
`endif

    logic [SW-1:0]             r_slot;
    logic [CW-1:0]             r_pix;
    logic [OUT_DATA_WIDTH-1:0] r_word;
    logic [EW-1:0]             r_mem [FIFO_DEPTH];
    logic [AW:0]               r_wp;
    logic [AW:0]               r_rp;
    logic [OUT_DATA_WIDTH-1:0] r_tdata;
    logic                      r_tvalid;
    logic                      r_tlast;
    logic                      r_overflow;

    logic [OUT_DATA_WIDTH-1:0] w_word;
    logic [AW:0]               w_level;
    logic                      w_last_beat;
    logic                      w_full_beat;
    logic                      w_done;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_push;

    // slots above the current lane stay zero because r_word is cleared on every completed word
    always_comb begin
        w_word = r_word;
        for (int l = 0; l < PPC; l++)
            w_word[(int'(r_slot) + l) * PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH] = in_pixel_data[l * PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH];
    end

    assign w_last_beat = int'(r_pix) == FRAME_PIXELS - PPC;
    assign w_full_beat = int'(r_slot) == PPW - PPC;
`ifdef PIXEL_PACKER_PARTIAL_WORD_EN
    assign w_done      = in_pixel_data_valid & (w_full_beat | w_last_beat);
`else
    assign w_done      = in_pixel_data_valid & w_full_beat;
`endif
    assign w_level     = r_wp - r_rp;
    assign w_empty     = w_level == '0;
    assign w_full      = w_level == (AW + 1)'(FIFO_DEPTH);
    assign w_pop       = !w_empty & (!r_tvalid | out_tready);
    assign w_push      = w_done & (!w_full | w_pop);

    always_ff @(posedge clk)
        if (w_push)
            r_mem[r_wp[AW-1:0]] <= {w_last_beat, w_word};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot     <= '0;
            r_pix      <= '0;
            r_word     <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (in_pixel_data_valid) begin
                r_word <= w_done ? '0 : w_word;
                r_slot <= w_done ? '0 : r_slot + SW'(PPC);
                r_pix  <= w_last_beat ? '0 : r_pix + CW'(PPC);
            end
            if (w_push)
                r_wp <= r_wp + (AW + 1)'(1);
            if (w_pop) begin
                r_rp               <= r_rp + (AW + 1)'(1);
                {r_tlast, r_tdata} <= r_mem[r_rp[AW-1:0]];
            end
            r_tvalid <= w_pop | (r_tvalid & !out_tready);
            if (w_done & !w_push)
                r_overflow <= 1'b1;
        end
    end

    assign out_tdata  = r_tdata;
    assign out_tvalid = r_tvalid;
    assign out_tlast  = r_tlast;
    assign overflow   = r_overflow;
    assign fifo_level = w_level;
endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb_pixel_stream_packer: scoreboard bench; unit a is PPC=1 with a 4-deep FIFO, unit b is PPC=2.
// Unit c (FRAME_PIXELS=9) exists only when PIXEL_PACKER_PARTIAL_WORD_EN is defined.
module tb_pixel_stream_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  a_pix = '0;
    logic        a_vld = 1'b0, a_rdy = 1'b0;
    logic [31:0] a_td;
    logic        a_tv, a_tl, a_ov;
    logic [2:0]  a_lvl;
    logic [15:0] b_pix = '0;
    logic        b_vld = 1'b0, b_rdy = 1'b0;
    logic [31:0] b_td;
    logic        b_tv, b_tl, b_ov;
    logic [4:0]  b_lvl;

    logic [32:0] qa[$];
    logic [32:0] qb[$];
    logic [31:0] m_word = '0;
    int          m_slot = 0, m_pix = 0;
    bit          bp = 1'b0;

    pixel_stream_packer #(.PIXEL_DATA_WIDTH(8), .PPC(1), .OUT_DATA_WIDTH(32), .FRAME_PIXELS(8), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .in_pixel_data(a_pix), .in_pixel_data_valid(a_vld),
        .out_tdata(a_td), .out_tvalid(a_tv), .out_tready(a_rdy), .out_tlast(a_tl),
        .overflow(a_ov), .fifo_level(a_lvl));

    pixel_stream_packer #(.PIXEL_DATA_WIDTH(8), .PPC(2), .OUT_DATA_WIDTH(32), .FRAME_PIXELS(8), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst(rst), .in_pixel_data(b_pix), .in_pixel_data_valid(b_vld),
        .out_tdata(b_td), .out_tvalid(b_tv), .out_tready(b_rdy), .out_tlast(b_tl),
        .overflow(b_ov), .fifo_level(b_lvl));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (bp) a_rdy = ~a_rdy;
            @(posedge clk);
            #1;
        end
    endtask

    // drives one beat into unit a and models the packer to queue the expected word
    task automatic px_a(input logic [7:0] p, input bit keep);
        m_word[8*m_slot +: 8] = p;
        m_slot++;
        m_pix++;
        if (m_slot == 4) begin
            if (keep) qa.push_back({m_pix == 8, m_word});
            m_word = '0;
            m_slot = 0;
        end
        if (m_pix == 8) m_pix = 0;
        if (bp) a_rdy = ~a_rdy;
        a_pix = p;
        a_vld = 1'b1;
        @(posedge clk);
        #1;
        a_vld = 1'b0;
    endtask

    task automatic beat_b(input logic [15:0] p);
        b_pix = p;
        b_vld = 1'b1;
        @(posedge clk);
        #1;
        b_vld = 1'b0;
    endtask

    task automatic drain_a;
        for (int i = 0; i < 200 && qa.size() != 0; i++) idle(1);
        check("a_drain", qa.size(), 0);
    endtask

    task automatic chk_rst_a;
        check("a_rst_tdata", a_td, 0);
        check("a_rst_tvalid", a_tv, 0);
        check("a_rst_tlast", a_tl, 0);
        check("a_rst_overflow", a_ov, 0);
        check("a_rst_level", a_lvl, 0);
    endtask

    logic        s_a = 1'b0;
    logic [32:0] h_a = '0;
    always @(negedge clk) begin
        if (rst) s_a = 1'b0;
        else begin
            if (s_a) check("a_hold", {a_tv, a_tl, a_td}, {1'b1, h_a});
            if (a_tv && a_rdy) begin
                if (qa.size() == 0) check("a_sb_count", qa.size(), 1);
                else check("a_word", {a_tl, a_td}, qa.pop_front());
            end
            s_a = a_tv && !a_rdy;
            h_a = {a_tl, a_td};
        end
    end

    always @(negedge clk)
        if (!rst && b_tv && b_rdy) begin
            if (qb.size() == 0) check("b_sb_count", qb.size(), 1);
            else check("b_word", {b_tl, b_td}, qb.pop_front());
        end

`ifdef PIXEL_PACKER_PARTIAL_WORD_EN
    logic [7:0]  c_pix = '0;
    logic        c_vld = 1'b0, c_rdy = 1'b1;
    logic [31:0] c_td;
    logic        c_tv, c_tl, c_ov;
    logic [4:0]  c_lvl;
    logic [32:0] qc[$];

    pixel_stream_packer #(.PIXEL_DATA_WIDTH(8), .PPC(1), .OUT_DATA_WIDTH(32), .FRAME_PIXELS(9), .FIFO_DEPTH(16)) u_c (
        .clk(clk), .rst(rst), .in_pixel_data(c_pix), .in_pixel_data_valid(c_vld),
        .out_tdata(c_td), .out_tvalid(c_tv), .out_tready(c_rdy), .out_tlast(c_tl),
        .overflow(c_ov), .fifo_level(c_lvl));

    always @(negedge clk)
        if (!rst && c_tv && c_rdy) begin
            if (qc.size() == 0) check("c_sb_count", qc.size(), 1);
            else check("c_word", {c_tl, c_td}, qc.pop_front());
        end
`endif

    initial begin
        #500us;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] bw;
        repeat (3) @(posedge clk);
        #1;
        chk_rst_a();
        check("b_rst_tvalid", b_tv, 0);
        check("b_rst_tdata", b_td, 0);
        check("b_rst_level", b_lvl, 0);
        rst = 1'b0;

        // two-pixel beats with growing gaps must pack identically
        b_rdy = 1'b1;
        bw = '0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 4; k++) begin
                logic [7:0] lo;
                lo = 8'(8 * f + 2 * k + 1);
                bw[16*(k%2) +: 16] = {lo + 8'd1, lo};
                if (k % 2 == 1) qb.push_back({k == 3, bw});
                beat_b({lo + 8'd1, lo});
                idle(k + f);
            end
        for (int i = 0; i < 100 && qb.size() != 0; i++) idle(1);
        check("b_drain", qb.size(), 0);

        // latency: word complete at edge N, visible in FIFO after N, on the output after N+1
        a_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) px_a(8'(i), 1'b1);
        px_a(8'h04, 1'b1);
        check("lat_tvalid_n", a_tv, 0);
        check("lat_level_n", a_lvl, 1);
        px_a(8'h05, 1'b1);
        check("lat_tvalid_n1", a_tv, 1);
        check("lat_tdata_n1", a_td, 32'h04030201);
        for (int i = 6; i <= 8; i++) px_a(8'(i), 1'b1);
        drain_a();

        // ready toggling every cycle during a two-frame burst
        bp = 1'b1;
        for (int i = 0; i < 16; i++) px_a(8'(8'h50 + i), 1'b1);
        drain_a();
        bp = 1'b0;

        // six words into a stalled 4-deep FIFO: word 5 is dropped
        a_rdy = 1'b0;
        for (int i = 0; i < 24; i++) begin
            px_a(8'(8'h20 + i), i < 20);
            if (i == 22) check("ovf_before_drop", a_ov, 0);
        end
        check("ovf_after_drop", a_ov, 1);
        check("ovf_level", a_lvl, 4);
        check("ovf_tvalid", a_tv, 1);
        check("ovf_head", {a_tl, a_td}, {1'b0, 32'h23222120});
        idle(3);
        check("ovf_sticky_stall", a_ov, 1);
        a_rdy = 1'b1;
        drain_a();
        check("ovf_sticky_drain", a_ov, 1);
        check("ovf_level_drained", a_lvl, 0);

        // reset mid-frame with two words held
        a_rdy = 1'b0;
        for (int i = 0; i < 11; i++) px_a(8'(8'h30 + i), 1'b1);
        check("mid_level", a_lvl, 1);
        check("mid_tvalid", a_tv, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_rst_a();
        rst = 1'b0;
        qa.delete();
        m_word = '0;
        m_slot = 0;
        m_pix = 0;
        a_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) px_a(8'(8'h40 + i), 1'b1);
        drain_a();

`ifdef PIXEL_PACKER_PARTIAL_WORD_EN
        qc.push_back({1'b0, 32'h14131211});
        qc.push_back({1'b0, 32'h18171615});
        qc.push_back({1'b1, 32'h00000019});
        qc.push_back({1'b0, 32'h24232221});
        for (int i = 0; i < 13; i++) begin
            c_pix = i < 9 ? 8'(8'h11 + i) : 8'(8'h21 + i - 9);
            c_vld = 1'b1;
            @(posedge clk);
            #1;
            c_vld = 1'b0;
        end
        for (int i = 0; i < 100 && qc.size() != 0; i++) idle(1);
        check("c_drain", qc.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
